// File: rtl/writeback_stage.sv
// Writeback stage: formats load data, latches the pending result on the
// LATCH phase and commits it to the 32x32 register file on COMMIT.
module writeback_stage #(
   parameter int RF_DEPTH = 32,
   parameter int RA_REG   = 31
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  start,
   input  logic [5:0]  op,
   input  logic [5:0]  funct,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [31:0] alu_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] mem_i,
   input  logic [31:0] pc_i,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   output logic [31:0] rd1,
   output logic [31:0] rd2,
   output logic        wb_valid_o,
   output logic [4:0]  wb_addr_o,
   output logic [31:0] wb_data_o,
   output logic        misalign_o,
   output logic [31:0] retired_o
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_LH    = 6'b100001;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_LBU   = 6'b100100;
   localparam logic [5:0] OP_LHU   = 6'b100101;
   localparam logic [5:0] FN_JR    = 6'b001000;
   localparam logic [3:0] PH_LATCH  = 4'b0100;
   localparam logic [3:0] PH_COMMIT = 4'b1000;

   logic [31:0] rf [RF_DEPTH];

   logic        pend_we;
   logic [4:0]  pend_dst;
   logic [31:0] pend_data;

   logic        lat_we;
   logic        lat_mis;
   logic [4:0]  lat_dst;
   logic [31:0] lat_data;

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic        is_latch;
   logic        is_commit;
   logic        commit_ok;
   logic        unused_addr;

   assign unused_addr = ^addr_i[31:2];

   assign is_latch  = (start == PH_LATCH);
   assign is_commit = (start == PH_COMMIT);
   assign commit_ok = pend_we && (pend_dst != 5'd0);

   // little-endian lane select; addr_i[1:0] picks byte, addr_i[1] picks half
   assign ld_byte = mem_i[{addr_i[1:0], 3'b000} +: 8];
   assign ld_half = addr_i[1] ? mem_i[31:16] : mem_i[15:0];

   always_comb begin
      lat_we   = 1'b0;
      lat_mis  = 1'b0;
      lat_dst  = rt;
      lat_data = alu_i;
      unique case (1'b1)
         (op == OP_RTYPE): begin
            lat_dst = rd;
            lat_we  = (funct != FN_JR);
         end
         (op[5:3] == 3'b001): begin
            lat_we = 1'b1;
         end
         (op == OP_JAL): begin
            lat_dst  = 5'(RA_REG);
            lat_data = pc_i + 32'd8;
            lat_we   = 1'b1;
         end
         (op == OP_LB): begin
            lat_data = {{24{ld_byte[7]}}, ld_byte};
            lat_we   = 1'b1;
         end
         (op == OP_LBU): begin
            lat_data = {24'd0, ld_byte};
            lat_we   = 1'b1;
         end
         (op == OP_LH): begin
            lat_data = {{16{ld_half[15]}}, ld_half};
            lat_mis  = addr_i[0];
            lat_we   = !addr_i[0];
         end
         (op == OP_LHU): begin
            lat_data = {16'd0, ld_half};
            lat_mis  = addr_i[0];
            lat_we   = !addr_i[0];
         end
         (op == OP_LW): begin
            lat_data = mem_i;
            lat_mis  = |addr_i[1:0];
            lat_we   = ~|addr_i[1:0];
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
         pend_we    <= 1'b0;
         pend_dst   <= '0;
         pend_data  <= '0;
         wb_valid_o <= 1'b0;
         wb_addr_o  <= '0;
         wb_data_o  <= '0;
         misalign_o <= 1'b0;
         retired_o  <= '0;
      end else begin
         wb_valid_o <= 1'b0;
         if (is_latch) begin
            pend_we   <= lat_we;
            pend_dst  <= lat_dst;
            pend_data <= lat_data;
            if (lat_mis) misalign_o <= 1'b1;
         end
         if (is_commit) begin
            retired_o <= retired_o + 32'd1;
            pend_we   <= 1'b0;
            if (commit_ok) begin
               rf[pend_dst] <= pend_data;
               wb_valid_o   <= 1'b1;
               wb_addr_o    <= pend_dst;
               wb_data_o    <= pend_data;
            end
         end
      end
   end

   // decode sees the committing value in the same cycle via bypass
   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (ra1 != 5'd0) begin
         if (is_commit && commit_ok && ra1 == pend_dst) rd1 = pend_data;
         else                                             rd1 = rf[ra1];
      end
      if (ra2 != 5'd0) begin
         if (is_commit && commit_ok && ra2 == pend_dst) rd2 = pend_data;
         else                                             rd2 = rf[ra2];
      end
   end

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed cases plus random
// instructions checked against an arithmetic reference model.
module tb_writeback_stage;

   logic        clk;
   logic        rst;
   logic [3:0]  start;
   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [31:0] alu_i;
   logic [31:0] addr_i;
   logic [31:0] mem_i;
   logic [31:0] pc_i;
   logic [4:0]  ra1;
   logic [4:0]  ra2;
   logic [31:0] rd1;
   logic [31:0] rd2;
   logic        wb_valid_o;
   logic [4:0]  wb_addr_o;
   logic [31:0] wb_data_o;
   logic        misalign_o;
   logic [31:0] retired_o;

   writeback_stage dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .funct(funct),
      .rt(rt), .rd(rd), .alu_i(alu_i), .addr_i(addr_i),
      .mem_i(mem_i), .pc_i(pc_i), .ra1(ra1), .ra2(ra2),
      .rd1(rd1), .rd2(rd2), .wb_valid_o(wb_valid_o),
      .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
      .misalign_o(misalign_o), .retired_o(retired_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } exp_t;

   exp_t        q[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] m_rf [32];
   logic [31:0] m_ret;
   bit          m_mis;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] a);
      return (a == 0) ? 32'd0 : m_rf[a];
   endfunction

   function automatic void model(
      input logic [5:0] o, input logic [5:0] f,
      input logic [4:0] t, input logic [4:0] d,
      input logic [31:0] alu, input logic [31:0] addr,
      input logic [31:0] mem, input logic [31:0] pc,
      output bit we, output logic [4:0] dst,
      output logic [31:0] data, output bit mis);
      int unsigned v;
      int unsigned k;
      we = 0; mis = 0; dst = t; data = alu;
      k = addr % 4;
      if (o == 0) begin
         dst = d; we = (f != 8);
      end else if (o >= 8 && o <= 15) begin
         we = 1;
      end else if (o == 3) begin
         dst = 31; data = pc + 8; we = 1;
      end else if (o == 32 || o == 36) begin
         v = (mem >> (8 * k)) % 256;
         if (o == 32 && v >= 128) v = v - 256;
         data = v; we = 1;
      end else if (o == 33 || o == 37) begin
         v = (mem >> (16 * (k / 2))) % 65536;
         if (o == 33 && v >= 32768) v = v - 65536;
         data = v;
         mis = (k % 2) != 0;
         we = !mis;
      end else if (o == 35) begin
         data = mem;
         mis = (k != 0);
         we = !mis;
      end
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
      m_ret = 0;
      m_mis = 0;
      q.delete();
   endtask

   // full four-phase instruction; dbl inserts an overwritten junk latch
   task automatic run_instr(
      input logic [5:0] o, input logic [5:0] f,
      input logic [4:0] t, input logic [4:0] d,
      input logic [31:0] alu, input logic [31:0] addr,
      input logic [31:0] mem, input logic [31:0] pc,
      input bit dbl);
      bit          we;
      bit          mis;
      logic [4:0]  dst;
      logic [31:0] data;
      logic [4:0]  rsel;
      model(o, f, t, d, alu, addr, mem, pc, we, dst, data, mis);
      start = 4'b0001; tick();
      start = 4'b0010; tick();
      if (dbl) begin
         start = 4'b0100; op = 0; funct = 6'h20;
         rd = 5'($urandom); alu_i = $urandom;
         tick();
      end
      start = 4'b0100;
      op = o; funct = f; rt = t; rd = d;
      alu_i = alu; addr_i = addr; mem_i = mem; pc_i = pc;
      tick();
      m_mis = m_mis | mis;
      chk("misalign_latch", misalign_o, m_mis);
      if (we && dst != 0) q.push_back('{a: dst, d: data});
      start = 4'b1000;
      rsel = 5'($urandom);
      ra1 = rsel;
      ra2 = dst;
      #1;
      chk("bypass_rd1", rd1,
          (we && dst != 0 && rsel == dst) ? data : m_read(rsel));
      chk("bypass_rd2", rd2, (we && dst != 0) ? data : m_read(dst));
      tick();
      start = 4'b0001;
      if (we && dst != 0) m_rf[dst] = data;
      m_ret = m_ret + 1;
      chk("retired", retired_o, m_ret);
      ra1 = dst;
      #1;
      chk("rf_read", rd1, m_read(dst));
   endtask

   // monitor: every write pulse must match the oldest expected commit
   always @(negedge clk) begin
      if (!rst && wb_valid_o) begin
         if (q.size() == 0) begin
            chk("wb_unexpected", 32'(wb_valid_o), 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("wb_addr", 32'(wb_addr_o), 32'(e.a));
            chk("wb_data", wb_data_o, e.d);
         end
      end
   end

   logic [5:0] ops [22] = '{6'd0, 6'd0, 6'd8, 6'd9, 6'd10, 6'd11,
                            6'd12, 6'd13, 6'd14, 6'd15, 6'd3, 6'd32,
                            6'd36, 6'd33, 6'd37, 6'd35, 6'd35, 6'd33,
                            6'd43, 6'd4, 6'd2, 6'd63};

   initial begin
      rst = 1; start = 0; op = 0; funct = 0; rt = 0; rd = 0;
      alu_i = 0; addr_i = 0; mem_i = 0; pc_i = 0; ra1 = 0; ra2 = 0;
      m_reset();
      tick(); tick();
      rst = 0;
      for (int i = 0; i < 32; i++) begin
         ra1 = 5'(i); ra2 = 5'(31 - i);
         #1;
         chk("reset_rd1", rd1, 32'd0);
         chk("reset_rd2", rd2, 32'd0);
      end
      chk("reset_retired", retired_o, 32'd0);
      chk("reset_valid", 32'(wb_valid_o), 32'd0);
      chk("reset_misalign", 32'(misalign_o), 32'd0);

      run_instr(6'b100001, 0, 5, 0, 0, 32'h4926, 32'h8001_7FFF, 0, 0);
      chk("lh_value", m_rf[5], 32'hFFFF8001);
      run_instr(6'b100001, 0, 6, 0, 0, 32'h4925, 32'h8001_7FFF, 0, 0);
      chk("lh_mis_flag", 32'(misalign_o), 32'd1);
      run_instr(6'b001101, 0, 9, 0, 32'hA, 0, 0, 0, 0);
      run_instr(6'b001101, 0, 0, 0, 32'hA, 0, 0, 0, 0);
      run_instr(6'b000011, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0);
      ra1 = 31; #1;
      chk("jal_wrap", rd1, 32'h4);
      run_instr(6'b000000, 6'h20, 0, 3, 32'h1234, 0, 0, 0, 0);

      start = 4'b0110; op = 0; funct = 6'h20; rd = 12; alu_i = 32'h55;
      tick();
      start = 4'b1100; tick();
      start = 4'b1111; tick();
      start = 4'b0000;
      ra1 = 12; #1;
      chk("badphase_ret", retired_o, m_ret);
      chk("badphase_rf", rd1, 32'd0);

      start = 4'b0001; tick();
      start = 4'b0010; tick();
      start = 4'b0100; op = 6'b100011; rt = 7; addr_i = 32'h100;
      mem_i = 32'hCAFE_F00D;
      tick();
      rst = 1; start = 4'b0000; tick();
      rst = 0; m_reset();
      start = 4'b1000; tick();
      start = 4'b0001;
      m_ret = 1;
      ra1 = 7; ra2 = 9; #1;
      chk("rstmid_reg7", rd1, 32'd0);
      chk("rstmid_reg9", rd2, 32'd0);
      chk("rstmid_ret", retired_o, m_ret);
      chk("rstmid_mis", 32'(misalign_o), 32'd0);

      for (int n = 0; n < 300; n++) begin
         logic [5:0] o;
         logic [5:0] f;
         o = ops[$urandom_range(21)];
         f = ($urandom_range(3) == 0) ? 6'b001000 : 6'($urandom);
         run_instr(o, f, 5'($urandom), 5'($urandom), $urandom,
                   $urandom, $urandom, $urandom,
                   $urandom_range(7) == 0);
      end
      for (int i = 0; i < 32; i++) begin
         ra1 = 5'(i); #1;
         chk("final_rf", rd1, m_read(5'(i)));
      end
      tick(); tick();
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final stage of the multi-cycle CPU, directly downstream of the memory stage.
- Consumes four inputs: the current phase (the one-hot `t` from the clock-phase generator), the opcode, the ALU result, and the raw memory word.
- Formats load data, selects the destination register and commits the result into a 32x32 register file.
- Provides two combinational read ports for decode, plus a retired-instruction counter.

Parameters:
- RF_DEPTH, 32, number of architectural registers (index width fixed at 5).
- RA_REG, 31, link register written by jal.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  4  one-hot phase from the clock-phase generator (4'b0001..4'b1000).
- op  input  6  instruction opcode [31:26].
- funct  input  6  instruction funct [5:0], used only when op=0.
- rt  input  5  instruction rt field.
- rd  input  5  instruction rd field.
- alu_i  input  32  ALU result.
- addr_i  input  32  effective memory address (same value the memory stage receives).
- mem_i  input  32  raw aligned word read by the memory stage.
- pc_i  input  32  PC of the current instruction.
- ra1  input  5  read address port 1.
- ra2  input  5  read address port 2.
- rd1  output  32  read data port 1.
- rd2  output  32  read data port 2.
- wb_valid_o  output  1  one-cycle pulse when a register write commits.
- wb_addr_o  output  5  committed destination register.
- wb_data_o  output  32  committed data.
- misalign_o  output  1  sticky flag: a load was misaligned.
- retired_o  output  32  count of instructions completed.

Behaviour:
- **Reset.** All 32 registers, wb_valid_o, wb_addr_o, wb_data_o, misalign_o, retired_o and the internal pending registers are cleared to 0 on the first rising edge with rst=1. Reset has priority over every phase. A pending commit interrupted by reset is discarded.
- **Phase action rule.** Action is taken only when `start` is exactly 4'b0100 (LATCH) or 4'b1000 (COMMIT). Any other value, including non-one-hot values, causes no state change.
- **LATCH edge** (start=4'b0100): compute and register pend_we, pend_dst and pend_data. Decode:
  - R-type, op=000000: dst=rd, data=alu_i, we=1. Exception: funct=001000 (jr), which gives we=0.
  - I-ALU, op in {001000, 001001, 001010, 001011, 001100, 001101, 001110, 001111}: dst=rt, data=alu_i, we=1.
  - jal, op=000011: dst=RA_REG, data=pc_i+8 (32-bit wrap), we=1.
  - Loads: dst=rt, we=1 only if aligned. Byte lane k occupies mem_i[8k+7:8k] with k=addr_i[1:0] (little-endian).
    - lb (100000): sign-extend lane k.
    - lbu (100100): zero-extend lane k.
    - lh (100001): sign-extend mem_i[16h+15:16h] with h=addr_i[1].
    - lhu (100101): zero-extend the same halfword.
    - lw (100011): mem_i unchanged.
    - Misaligned means addr_i[0]=1 for lh/lhu, or addr_i[1:0]≠0 for lw. A misaligned load gives we=0 and sets misalign_o=1 on this same edge; misalign_o is sticky until reset.
  - All other ops (stores, branches, j, unknown): we=0.
- **COMMIT edge** (start=4'b1000):
  - If pend_we=1 and pend_dst≠0: regfile[pend_dst]<=pend_data; wb_valid_o<=1; wb_addr_o<=pend_dst; wb_data_o<=pend_data.
  - Otherwise wb_valid_o<=0. wb_addr_o and wb_data_o hold their values.
  - retired_o increments by 1 on every COMMIT edge, whatever pend_we is, and wraps 0xFFFFFFFF→0.
  - pend_we clears after commit.
- **wb_valid_o** is 0 on every edge that is not a committing COMMIT edge, so it is high for exactly one cycle.
- **Register 0** always reads 0 and is never written.
- **Read ports** are combinational: rdN = (raN==0) ? 0 : regfile[raN].
  - Bypass: while start=4'b1000, pend_we=1, pend_dst≠0 and raN==pend_dst, rdN=pend_data.
- **Simultaneous events:** a LATCH overwrites any uncommitted pending values. The last LATCH before COMMIT wins.
- **Latency:** data reaches the register file on the COMMIT edge, one phase after LATCH. It is visible on the read ports during the COMMIT cycle via bypass.

Test Plan:
1. **Reset.** Drive rst=1 for 2 cycles → rd1=rd2=0 for all ra; retired_o=0; wb_valid_o=0; misalign_o=0.
2. **lh aligned.** op=100001, rt=5, addr_i=0x00004926, mem_i=0x8001_7FFF; cycle the phases → on COMMIT, wb_valid_o pulses, wb_addr_o=5, wb_data_o=0xFFFF8001; afterwards ra1=5 gives rd1=0xFFFF8001; retired_o=1.
3. **lh misaligned.** op=100001, rt=6, addr_i=0x00004925 → misalign_o=1 after the LATCH edge; no wb_valid_o pulse; reg6 stays 0; retired_o still increments.
4. **ALU write, r0, jal.**
   - op=001101, rt=9, alu_i=0x0000000A → reg9=0x0000000A.
   - The same instruction with rt=0 → no pulse, and reg0 reads 0.
   - jal with pc_i=0xFFFFFFFC → reg31=0x00000004 (wrap).
5. **Bypass and bad phase.**
   - During the COMMIT cycle of R-type rd=3, alu_i=0x1234, ra2=3 → rd2=0x1234 in that same cycle.
   - start=4'b0110 → no latch, no commit, and the counter is unchanged.
6. **Reset mid-operation.** Assert rst for one cycle between LATCH and COMMIT of an lw to rt=7 → the following COMMIT writes nothing, reg7=0, and retired_o counts from 0.
